// File: rtl/bird_motion_ctrl_if.sv
// Bird motion control bus.
//   frame_tick  1-cycle pulse per video frame
//   flap        spacebar level from the keyboard block
//   collide     pipe/bird overlap flag, only looked at on frame_tick
//   bird_top    sprite top line
//   bird_bot    sprite bottom line (bird_top + sprite height)
//   state       0=IDLE 1=PLAY 2=DEAD
//   game_over   1-cycle pulse on entry to DEAD
// master drives the inputs of the motion block; slave is the motion block.
interface bird_motion_ctrl_if;
  logic       frame_tick;
  logic       flap;
  logic       collide;
  logic [9:0] bird_top;
  logic [9:0] bird_bot;
  logic [1:0] state;
  logic       game_over;

  modport master (
    output frame_tick, flap, collide,
    input  bird_top, bird_bot, state, game_over
  );

  modport slave (
    input  frame_tick, flap, collide,
    output bird_top, bird_bot, state, game_over
  );
endinterface

// File: rtl/bird_motion_ctrl.sv
// Game-state and vertical physics for the bird sprite.
// Gravity pulls the bird down once per frame (velocity capped at MAX_FALL),
// a flap edge loads an upward velocity, the ceiling clamps and the floor kills.
// Ports:
//   clk    in  board clock
//   rst_n  in  asynchronous reset, active low
//   bus    slave side of bird_motion_ctrl_if (tick/flap/collide in,
//          bird_top/bird_bot/state/game_over out)
module bird_motion_ctrl #(
  parameter int SCREEN_H = 480,
  parameter int BIRD_H   = 40,
  parameter int START_Y  = 220,
  parameter int FLAP_VEL = 8,
  parameter int GRAVITY  = 1,
  parameter int MAX_FALL = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  bird_motion_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_DEAD = 2'd2;

  localparam logic [9:0]        START10  = 10'(START_Y);
  localparam logic [9:0]        BIRD10   = 10'(BIRD_H);
  localparam logic [9:0]        FLOOR10  = 10'(SCREEN_H - BIRD_H);
  localparam logic [10:0]       FLOOR11  = 11'(SCREEN_H - BIRD_H);
  localparam logic signed [5:0] NEG_FLAP = 6'(-FLAP_VEL);
  localparam logic signed [6:0] GRAV7    = 7'(GRAVITY);
  localparam logic signed [6:0] MAXF7    = 7'(MAX_FALL);

  // Gravity step with the fall-speed cap; one extra bit so the sum never wraps.
  function automatic logic signed [5:0] sat_fall(input logic signed [5:0] v);
    logic signed [6:0] s;
    s = {v[5], v} + GRAV7;
    if (s > MAXF7) return MAXF7[5:0];
    else           return s[5:0];
  endfunction

  logic [1:0]        state_p1, state_n;
  logic [9:0]        y_p1, y_n;
  logic signed [5:0] vel_p1, vel_n;
  logic              pend_p1, pend_n;
  logic              go_p1, go_n;
  logic              flap_q;

  logic              fe;
  logic              eff;
  logic signed [5:0] vel_cand;
  logic [10:0]       y_cand;

  // ---- stage 0: edge detect, candidate motion, next-state decision ----
  always_comb begin
    fe       = bus.flap & ~flap_q;
    // A flap edge landing on the tick cycle itself still counts for that tick.
    eff      = pend_p1 | fe;
    vel_cand = eff ? NEG_FLAP : sat_fall(vel_p1);
    // 11-bit sum: bit 10 set means the bird went above line 0.
    y_cand   = {1'b0, y_p1} + {{5{vel_cand[5]}}, vel_cand};

    state_n = state_p1;
    y_n     = y_p1;
    vel_n   = vel_p1;
    pend_n  = pend_p1;
    go_n    = 1'b0;

    case (state_p1)
      S_PLAY: begin
        if (bus.frame_tick) begin
          pend_n = 1'b0;
          if (bus.collide) begin
            state_n = S_DEAD;
            go_n    = 1'b1;
          end else if (y_cand[10]) begin
            y_n   = '0;
            vel_n = '0;
          end else if (y_cand >= FLOOR11) begin
            y_n     = FLOOR10;
            vel_n   = '0;
            state_n = S_DEAD;
            go_n    = 1'b1;
          end else begin
            y_n   = y_cand[9:0];
            vel_n = vel_cand;
          end
        end else if (fe) begin
          pend_n = 1'b1;
        end
      end
      S_DEAD: begin
        if (fe) begin
          state_n = S_IDLE;
          y_n     = START10;
          vel_n   = '0;
          pend_n  = 1'b0;
        end
      end
      default: begin
        // IDLE and the unused code 3: park at the start line; the entering
        // edge is remembered so the first tick in PLAY is a flap.
        y_n    = START10;
        vel_n  = '0;
        pend_n = fe;
        if (fe) state_n = S_PLAY;
      end
    endcase
  end

  // ---- stage 1: registered state and outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1 <= S_IDLE;
      y_p1     <= START10;
      vel_p1   <= '0;
      pend_p1  <= 1'b0;
      go_p1    <= 1'b0;
      flap_q   <= 1'b0;
    end else begin
      state_p1 <= state_n;
      y_p1     <= y_n;
      vel_p1   <= vel_n;
      pend_p1  <= pend_n;
      go_p1    <= go_n;
      flap_q   <= bus.flap;
    end
  end

  assign bus.bird_top  = y_p1;
  assign bus.bird_bot  = y_p1 + BIRD10;
  assign bus.state     = state_p1;
  assign bus.game_over = go_p1;

endmodule

// File: tb/tb_bird_motion_ctrl.sv
module tb_bird_motion_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  bird_motion_ctrl_if bus ();

  bird_motion_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model: plain integers, rules taken straight from the game description.
  int m_state = 0;   // 0 idle, 1 play, 2 dead
  int m_y     = 220;
  int m_vel   = 0;
  bit m_pend  = 0;
  bit m_flapq = 0;
  bit m_go    = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_y = 220; m_vel = 0; m_pend = 0; m_flapq = 0; m_go = 0;
    end else begin
      bit edge_seen, flap_now;
      int nv, ny;
      edge_seen = bus.flap && !m_flapq;
      flap_now  = m_pend || edge_seen;
      m_go      = 0;
      if (m_state == 1) begin
        if (bus.frame_tick) begin
          m_pend = 0;
          if (bus.collide) begin
            m_state = 2; m_go = 1;
          end else begin
            nv = flap_now ? -8 : ((m_vel + 1 > 10) ? 10 : m_vel + 1);
            ny = m_y + nv;
            if (ny < 0) begin
              m_y = 0; m_vel = 0;
            end else if (ny + 40 >= 480) begin
              m_y = 440; m_vel = 0; m_state = 2; m_go = 1;
            end else begin
              m_y = ny; m_vel = nv;
            end
          end
        end else if (edge_seen) begin
          m_pend = 1;
        end
      end else if (m_state == 2) begin
        if (edge_seen) begin
          m_state = 0; m_y = 220; m_vel = 0; m_pend = 0;
        end
      end else begin
        m_y = 220; m_vel = 0; m_pend = edge_seen;
        if (edge_seen) m_state = 1;
      end
      m_flapq = bus.flap;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    n_cmp++;
    if (bus.bird_top !== 10'(m_y) || bus.bird_bot !== 10'(m_y + 40) ||
        bus.state !== 2'(m_state) || bus.game_over !== m_go) begin
      n_fail++;
      $display("FAIL model_cmp t=%0t got top=%0d bot=%0d st=%0d go=%0d want top=%0d bot=%0d st=%0d go=%0d",
               $time, bus.bird_top, bus.bird_bot, bus.state, bus.game_over,
               m_y, m_y + 40, m_state, m_go);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk); bus.frame_tick = 1'b1;
    @(negedge clk); bus.frame_tick = 1'b0;
  endtask

  task automatic tick_flap(input bit hold);
    @(negedge clk); bus.frame_tick = 1'b1; bus.flap = 1'b1;
    @(negedge clk); bus.frame_tick = 1'b0;
    if (!hold) bus.flap = 1'b0;
  endtask

  task automatic press();
    @(negedge clk); bus.flap = 1'b1;
    @(negedge clk); bus.flap = 1'b0;
  endtask

  int exp_fall[12] = '{1, 3, 6, 10, 15, 21, 28, 36, 45, 55, 65, 75};

  initial begin
    bus.frame_tick = 1'b0;
    bus.flap       = 1'b0;
    bus.collide    = 1'b0;

    // 1: reset values, then idle ignores ticks
    repeat (2) @(negedge clk);
    chk("rst_top", bus.bird_top, 220);
    chk("rst_bot", bus.bird_bot, 260);
    chk("rst_state", bus.state, 0);
    chk("rst_go", bus.game_over, 0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_top", bus.bird_top, 220);
      chk("idle_state", bus.state, 0);
    end

    // 2: start, first tick flaps, second tick gravity
    press();
    chk("start_state", bus.state, 1);
    chk("start_top", bus.bird_top, 220);
    tick();
    chk("flap1_top", bus.bird_top, 212);
    tick();
    chk("flap2_top", bus.bird_top, 205);

    // 6a: collide kills without moving, flap returns to idle
    @(negedge clk); bus.frame_tick = 1'b1; bus.collide = 1'b1;
    @(negedge clk); bus.frame_tick = 1'b0; bus.collide = 1'b0;
    chk("coll_state", bus.state, 2);
    chk("coll_top", bus.bird_top, 205);
    chk("coll_go", bus.game_over, 1);
    tick();
    chk("dead_tick_top", bus.bird_top, 205);
    chk("dead_tick_go", bus.game_over, 0);
    press();
    chk("restart_state", bus.state, 0);
    chk("restart_top", bus.bird_top, 220);

    // 4: flap every tick up to the ceiling
    press();
    tick();
    chk("climb0_top", bus.bird_top, 212);
    tick_flap(1'b0);
    chk("climb1_top", bus.bird_top, 204);
    for (int i = 0; i < 28; i++) tick_flap(1'b0);
    chk("ceil_top", bus.bird_top, 0);
    chk("ceil_state", bus.state, 1);

    // 3: fall from the ceiling, velocity cap, floor death
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("fall_top", bus.bird_top, exp_fall[i]);
    end
    for (int i = 0; i < 100 && bus.state != 2; i++) tick();
    chk("floor_state", bus.state, 2);
    chk("floor_top", bus.bird_top, 440);
    chk("floor_bot", bus.bird_bot, 480);
    chk("floor_go", bus.game_over, 1);
    @(negedge clk);
    chk("floor_go_once", bus.game_over, 0);
    tick();
    chk("floor_frozen", bus.bird_top, 440);
    press();
    chk("floor_restart", bus.state, 0);

    // 5: coincident edge, then a held key counts once
    press();
    tick();
    chk("s5_first", bus.bird_top, 212);
    tick_flap(1'b1);
    chk("s5_coinc", bus.bird_top, 204);
    for (int i = 0; i < 10; i++) tick();
    chk("s5_held", bus.bird_top, 179);
    chk("s5_state", bus.state, 1);
    @(negedge clk); bus.flap = 1'b0;
    tick();
    chk("s5_grav", bus.bird_top, 182);

    // 6b: asynchronous reset mid-PLAY
    #2 rst_n = 1'b0;
    #1;
    chk("arst_top", bus.bird_top, 220);
    chk("arst_state", bus.state, 0);
    chk("arst_go", bus.game_over, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_state", bus.state, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
